// File: rtl/ov_capture.sv
// OV7670 capture front end: samples the camera pins in the system clock domain, packs
// RGB565 byte pairs into RGB444 pixels and writes them linearly into the frame buffer.
module ov_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  // One spare bit so the count can sit at the limit even when the frame fills the address space.
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  localparam logic [CNT_W-1:0] PIX_LIMIT = CNT_W'(PIX_TOTAL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic             pclk_s1, pclk_s2, pclk_s3;
  logic             vsync_s1, vsync_s2, vsync_s3;
  logic             href_s1, href_s2;
  logic [7:0]       data_s1, data_s2;
  logic             phase;
  logic [6:0]       hi_byte;
  logic [CNT_W-1:0] pix_cnt;
  logic             pclk_rise;
  logic             vs_rise;
  logic             vs_fall;

  // Asynchronous camera pins into the I_clk domain; pclk and vsync get an extra stage for edges.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pclk_s1  <= 1'b0;
      pclk_s2  <= 1'b0;
      pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
      vsync_s3 <= 1'b0;
      href_s1  <= 1'b0;
      href_s2  <= 1'b0;
      data_s1  <= 8'd0;
      data_s2  <= 8'd0;
    end else begin
      pclk_s1  <= cam_pclk;
      pclk_s2  <= pclk_s1;
      pclk_s3  <= pclk_s2;
      vsync_s1 <= cam_vsync;
      vsync_s2 <= vsync_s1;
      vsync_s3 <= vsync_s2;
      href_s1  <= cam_href;
      href_s2  <= href_s1;
      data_s1  <= cam_data;
      data_s2  <= data_s1;
    end
  end

  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign vs_rise   = vsync_s2 & ~vsync_s3;
  assign vs_fall   = ~vsync_s2 & vsync_s3;

  // Capture FSM; DONE separates the last pixel write from the frame_done pulse.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      hi_byte    <= 7'd0;
      pix_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 12'd0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_en) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (vs_fall) begin
            state   <= CAPTURE;
            pix_cnt <= '0;
            phase   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          if (!href_s2) begin
            phase <= 1'b0;
          end else if (pclk_rise) begin
            if (!phase) begin
              // Keep only the high-byte bits that survive the RGB565 -> RGB444 reduction.
              hi_byte <= {data_s2[7:4], data_s2[2:0]};
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (pix_cnt < PIX_LIMIT) begin
                wr_en   <= 1'b1;
                wr_addr <= pix_cnt[ADDR_W-1:0];
                wr_data <= {hi_byte, data_s2[7], data_s2[4:1]};
                pix_cnt <= pix_cnt + CNT_W'(1);
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          if (vs_rise) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          state      <= capture_en ? WAIT_VS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov_capture.sv
// Scoreboard bench for ov_capture on a reduced 8x4 frame with I_clk at 4x the camera pixel clock.
module tb_ov_capture;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned AW = 6;

  logic          I_clk, I_rst, capture_en;
  logic          cam_pclk, cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          wr_en, frame_done, overflow, busy;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  bit mon_en = 0;
  int exp_addr = 0;
  logic [AW+11:0] exp_q[$];

  ov_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .overflow(overflow), .busy(busy)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Monitor: every write must match the head of the expected queue.
  always @(negedge I_clk) begin
    if (mon_en && !I_rst) begin
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d data=%h, expected no write", wr_addr, wr_data);
        end else begin
          logic [AW+11:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            begin
              errors++;
              $display("FAIL write got addr=%0d data=%h, expected addr=%0d data=%h",
                       wr_addr, wr_data, e[AW+11:12], e[11:0]);
            end
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  task automatic cam_byte(input logic [7:0] b, input logic h);
    cam_pclk = 1'b0;
    cam_data = b;
    cam_href = h;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic pixel(input logic [7:0] a, input logic [7:0] b, input logic [11:0] d, input bit push);
    if (push) begin
      exp_q.push_back({AW'(exp_addr), d});
      exp_addr++;
    end
    cam_byte(a, 1'b1);
    cam_byte(b, 1'b1);
  endtask

  task automatic line_gap();
    cam_byte(8'h00, 1'b0);
    cam_byte(8'h00, 1'b0);
  endtask

  task automatic frame_start();
    exp_addr  = 0;
    cam_vsync = 1'b1;
    tick(4);
    cam_vsync = 1'b0;
    tick(4);
    line_gap();
  endtask

  task automatic frame_end();
    cam_byte(8'h00, 1'b0);
    cam_vsync = 1'b1;
    tick(12);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    int fd_base;
    I_rst = 1'b1; capture_en = 1'b0;
    cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    tick(5);
    @(negedge I_clk);
    chk_reset_outputs();

    // Reset in the middle of an active frame aborts it.
    tick(1);
    I_rst = 1'b0; capture_en = 1'b1;
    tick(2);
    frame_start();
    for (int i = 0; i < 3; i++) pixel(8'hF8, 8'h00, 12'hF00, 1'b0);
    fork
      begin
        for (int i = 0; i < 4; i++) cam_byte(8'hF8, 1'b1);
      end
      begin
        tick(3);
        I_rst = 1'b1;
        tick(3);
        @(negedge I_clk);
        chk_reset_outputs();
        @(posedge I_clk);
        #1 I_rst = 1'b0;
      end
    join
    cam_byte(8'h00, 1'b0);
    cam_vsync = 1'b1;
    tick(10);
    exp_q.delete();
    mon_en = 1'b1;

    // Full frame of red pixels.
    fd_base = fd_cnt;
    frame_start();
    for (int l = 0; l < int'(V); l++) begin
      for (int p = 0; p < int'(H); p++) pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
      if (l == 0) chk("busy_in_capture", 32'(busy), 1);
      line_gap();
    end
    frame_end();
    chk("full_queue_drained", exp_q.size(), 0);
    chk("full_frame_done", fd_cnt - fd_base, 1);
    chk("full_overflow", 32'(overflow), 0);
    chk("full_busy_after", 32'(busy), 0);

    // Colour mapping, odd trailing byte dropped, phase restarts on the next line.
    fd_base = fd_cnt;
    frame_start();
    pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
    pixel(8'h00, 8'h1F, 12'h00F, 1'b1);
    line_gap();
    pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
    cam_byte(8'h07, 1'b1);
    line_gap();
    pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
    pixel(8'h00, 8'h1F, 12'h00F, 1'b1);
    frame_end();
    chk("short_queue_drained", exp_q.size(), 0);
    chk("short_frame_done", fd_cnt - fd_base, 1);

    // One pixel too many: last one suppressed, overflow sticks into the next frame.
    fd_base = fd_cnt;
    frame_start();
    for (int l = 0; l < int'(V); l++) begin
      for (int p = 0; p < int'(H); p++) pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
      line_gap();
    end
    pixel(8'h00, 8'h1F, 12'h00F, 1'b0);
    frame_end();
    chk("ovf_queue_drained", exp_q.size(), 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_frame_done", fd_cnt - fd_base, 1);
    frame_start();
    pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
    frame_end();
    chk("ovf_next_queue_drained", exp_q.size(), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // capture_en dropped mid-frame: frame finishes, then the block stays idle.
    fd_base = fd_cnt;
    frame_start();
    pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
    pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
    chk("stop_busy_mid", 32'(busy), 1);
    capture_en = 1'b0;
    pixel(8'h00, 8'h1F, 12'h00F, 1'b1);
    pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
    frame_end();
    chk("stop_queue_drained", exp_q.size(), 0);
    chk("stop_frame_done", fd_cnt - fd_base, 1);
    chk("stop_busy_after", 32'(busy), 0);
    frame_start();
    pixel(8'hF8, 8'h00, 12'hF00, 1'b0);
    chk("stop_ignored_busy", 32'(busy), 0);
    pixel(8'h07, 8'hE0, 12'h0F0, 1'b0);
    frame_end();
    chk("stop_ignored_frame_done", fd_cnt - fd_base, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
